// File: rtl/gate_bist.sv
// gate_bist: built-in self-test sequencer for a 2-input combinational gate.
// Walks the four input vectors 00,01,10,11, holds each one for SETTLE_CYCLES
// clocks, then samples the gate output and compares it with a 4-bit truth table
// that was captured when the run started.
//
// Ports:
//   clk        - single clock, rising edge
//   reset_n    - asynchronous active-low reset
//   start      - run request; ignored while busy
//   truth      - expected output, truth[{in1,in2}], captured on accepted start
//   gate_in1/2 - gate inputs driven by the sequencer
//   gate_out   - gate output under test
//   busy       - run in progress
//   done       - one-cycle pulse at end of run
//   pass       - last completed run had no mismatches
//   fail_mask  - per-vector mismatch flags, live during a run
//   first_fail - lowest mismatching vector index (0 if none)
module gate_bist #(
    parameter int unsigned SETTLE_CYCLES = 120
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [3:0] truth,
    output logic       gate_in1,
    output logic       gate_in2,
    input  logic       gate_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [1:0] first_fail
);

    localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       vec_q, vec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       truth_q, truth_d;
    logic [1:0]       gate_in_q, gate_in_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [3:0]       fail_mask_q, fail_mask_d;
    logic [1:0]       first_fail_q, first_fail_d;

    logic             mismatch_c;
    logic [3:0]       mask_upd_c;

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            vec_q        <= 2'd0;
            cnt_q        <= '0;
            truth_q      <= 4'd0;
            gate_in_q    <= 2'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_mask_q  <= 4'd0;
            first_fail_q <= 2'd0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            cnt_q        <= cnt_d;
            truth_q      <= truth_d;
            gate_in_q    <= gate_in_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            fail_mask_q  <= fail_mask_d;
            first_fail_q <= first_fail_d;
        end
    end

    // Compare of the current vector, folded into the running mask
    always_comb begin
        mismatch_c = (gate_out != truth_q[vec_q]);
        mask_upd_c = fail_mask_q | (4'(mismatch_c) << vec_q);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        cnt_d        = cnt_q;
        truth_d      = truth_q;
        gate_in_d    = 2'd0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        pass_d       = pass_q;
        fail_mask_d  = fail_mask_q;
        first_fail_d = first_fail_q;

        case (state_q)
            ST_RUN: begin
                busy_d    = 1'b1;
                gate_in_d = vec_q;
                if (cnt_q == CNT_LAST) begin
                    fail_mask_d = mask_upd_c;
                    if (mismatch_c && (fail_mask_q == 4'd0)) begin
                        first_fail_d = vec_q;
                    end
                    if (vec_q == 2'd3) begin
                        state_d   = ST_FINISH;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        gate_in_d = 2'd0;
                        pass_d    = (mask_upd_c == 4'd0);
                    end else begin
                        vec_d     = 2'(vec_q + 2'd1);
                        cnt_d     = '0;
                        gate_in_d = 2'(vec_q + 2'd1);
                    end
                end else begin
                    cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // busy is low in IDLE and FINISH, so a start in either is accepted
        if ((state_q != ST_RUN) && start) begin
            state_d      = ST_RUN;
            truth_d      = truth;
            vec_d        = 2'd0;
            cnt_d        = '0;
            gate_in_d    = 2'd0;
            busy_d       = 1'b1;
            pass_d       = 1'b0;
            fail_mask_d  = 4'd0;
            first_fail_d = 2'd0;
        end
    end

    assign gate_in1   = gate_in_q[1];
    assign gate_in2   = gate_in_q[0];
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign fail_mask  = fail_mask_q;
    assign first_fail = first_fail_q;

endmodule

// File: tb/tb_gate_bist.sv
// Scoreboard bench for gate_bist: stimulus pushes the expected run result,
// a monitor checks every cycle and pops the entry when done pulses.
module tb_gate_bist;

    localparam int unsigned S = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [3:0] truth;
    logic       gate_in1, gate_in2, gate_out;
    logic       busy, done, pass;
    logic [3:0] fail_mask;
    logic [1:0] first_fail;
    logic [3:0] gate_tt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       pass;
        logic [3:0] mask;
        logic [1:0] first;
    } exp_t;

    exp_t q[$];
    int   run_len = 0;

    gate_bist #(.SETTLE_CYCLES(S)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .truth      (truth),
        .gate_in1   (gate_in1),
        .gate_in2   (gate_in2),
        .gate_out   (gate_out),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail_mask  (fail_mask),
        .first_fail (first_fail)
    );

    // Gate under test: an arbitrary 2-input function given by its truth table
    assign gate_out = gate_tt[{gate_in1, gate_in2}];

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] lowest(input logic [3:0] m);
        logic [1:0] r = 2'd0;
        for (int i = 3; i >= 0; i--) if (m[i]) r = 2'(i);
        return r;
    endfunction

    function automatic exp_t model(input logic [3:0] t, input logic [3:0] g);
        exp_t e;
        e.mask  = t ^ g;
        e.first = lowest(e.mask);
        e.pass  = (e.mask == 4'd0);
        return e;
    endfunction

    // Monitor: per-cycle sequence/live-result checks and end-of-run scoreboard
    always @(negedge clk) begin
        if (!reset_n) begin
            run_len = 0;
        end else if (busy) begin
            run_len++;
            chk("done_while_busy", 32'(done), 32'd0);
            chk("run_len_bound", 32'(run_len <= 4 * S), 32'd1);
            if (q.size() == 0) begin
                total++; bad++;
                $display("FAIL busy_without_run: busy=1 with no run issued at %0t", $time);
            end else begin
                int         samples;
                logic [3:0] live;
                samples = (run_len - 1) / S;
                live    = q[0].mask & 4'((1 << samples) - 1);
                chk("gate_vec", 32'({gate_in1, gate_in2}), 32'((run_len - 1) / S));
                chk("live_mask", 32'(fail_mask), 32'(live));
                chk("live_first", 32'(first_fail), 32'(lowest(live)));
                chk("pass_in_run", 32'(pass), 32'd0);
            end
        end else begin
            chk("gate_idle", 32'({gate_in1, gate_in2}), 32'd0);
            if (done) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL spurious_done: done=1 with no run pending at %0t", $time);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("run_len", 32'(run_len), 32'(4 * S));
                    chk("pass", 32'(pass), 32'(e.pass));
                    chk("fail_mask", 32'(fail_mask), 32'(e.mask));
                    chk("first_fail", 32'(first_fail), 32'(e.first));
                end
            end
            run_len = 0;
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_in1"}, 32'(gate_in1), 32'd0);
        chk({tag, "_in2"}, 32'(gate_in2), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_pass"}, 32'(pass), 32'd0);
        chk({tag, "_mask"}, 32'(fail_mask), 32'd0);
        chk({tag, "_first"}, 32'(first_fail), 32'd0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (q.size() != 0) begin
            total++; bad++;
            $display("FAIL timeout: %0d runs still pending at %0t", q.size(), $time);
            q.delete();
        end
    endtask

    // Issue one run; truth is scrambled right after capture to show it is ignored
    task automatic run(input logic [3:0] t, input logic [3:0] g);
        gate_tt = g;
        truth   = t;
        q.push_back(model(t, g));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        truth = 4'($urandom);
        wait_idle();
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        truth   = 4'd0;
        gate_tt = 4'b0110;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        run(4'b0110, 4'b0110);   // XOR: pass
        run(4'b0110, 4'b1000);   // AND: mask 1110, first 1
        run(4'b0110, 4'b1111);   // stuck at 1: mask 1001, first 0

        // Extra start pulses and a truth change while busy must be ignored
        gate_tt = 4'b0110;
        truth   = 4'b0110;
        q.push_back(model(4'b0110, 4'b0110));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        truth = 4'b1111;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Reset mid-run: outputs clear at once and the run never completes
        gate_tt = 4'b0110;
        truth   = 4'b0110;
        q.push_back(model(4'b0110, 4'b0110));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        #2;
        reset_n = 1'b0;
        q.delete();
        #1;
        check_all_zero("midrun_reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run(4'b0110, 4'b0110);

        // Start held high: back-to-back runs, each accepted in the FINISH cycle
        gate_tt = 4'b0110;
        truth   = 4'b0110;
        for (int i = 0; i < 3; i++) q.push_back(model(4'b0110, 4'b0110));
        start = 1'b1;
        repeat (40) @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Random truth tables against random or matching gates
        for (int i = 0; i < 12; i++) begin
            logic [3:0] t, g;
            t = 4'($urandom);
            g = ($urandom_range(0, 1) == 0) ? t : 4'($urandom);
            run(t, g);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gate_bist.md
# gate_bist

Built-in self-test sequencer for a 2-input combinational gate. It drives all four input combinations onto the gate under test and holds each vector for a programmable settle time. At the end of each settle window it samples the gate output and compares it against a 4-bit expected truth table captured at start. It reports pass/fail, a per-vector mismatch mask and the first failing vector, which moves exhaustive gate checking from simulation-only stimulus into synthesizable hardware.

## Interface
Parameters:
- SETTLE_CYCLES, 120, clock cycles each vector is held before sampling; legal range ≥ 1.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  run request, sampled on rising edge; ignored while busy=1.
- truth  input  4  expected gate output, truth[{in1,in2}]; captured on accepted start.
- gate_in1  output  1  drives gate input in1.
- gate_in2  output  1  drives gate input in2.
- gate_out  input  1  gate output under test.
- busy  output  1  high while a run is in progress.
- done  output  1  one-cycle pulse at end of run.
- pass  output  1  1 if last completed run had no mismatches.
- fail_mask  output  4  bit i set if vector i mismatched in current/last run.
- first_fail  output  2  index of lowest mismatching vector; 0 if none.

## Operation
- Vector index v = 0,1,2,3 in order; gate_in1 = v[1], gate_in2 = v[0].
- States:
  - IDLE: gate_in1/gate_in2 = 0, busy = 0.
  - RUN: vector v driven, settle counter active.
  - FINISH: single cycle asserting done.
- IDLE→RUN on start=1:
  - truth is captured into an internal register.
  - v and the settle counter are cleared to 0.
  - pass, fail_mask and first_fail are cleared to 0.
- RUN: the counter counts 0..SETTLE_CYCLES-1. On the edge where it ends at SETTLE_CYCLES-1:
  - gate_out is compared with truth_reg[v].
  - On mismatch, fail_mask[v] is set. If this is the first mismatch of the run, first_fail = v.
  - If v < 3: v increments and the counter resets, staying in RUN. If v = 3: go to FINISH.
- FINISH: done = 1, busy = 0, pass = (fail_mask == 0) including the v=3 result, gate inputs = 0. Next edge goes to IDLE.
- start while busy: ignored, with no effect on the run or on truth_reg.
- Changes to truth during a run: ignored.
- start during FINISH: accepted, because busy = 0. The next edge enters RUN with v = 0. The done pulse is still exactly one cycle.
- Counter width is clog2(SETTLE_CYCLES+1) bits and never wraps within a vector.

## Timing
- Reset (reset_n low, asynchronous): state = IDLE and every output = 0 (gate_in1, gate_in2, busy, done, pass, fail_mask, first_fail).
- Reset mid-run aborts the run immediately, with no done pulse.
- For a start accepted at edge E0:
  - busy = 1 and vector 0 are visible after E0.
  - Samples are taken at edges E0+S, E0+2S, E0+3S and E0+4S, where S = SETTLE_CYCLES.
  - done = 1 and busy = 0 during the cycle after E0+4S.
  - pass is valid from that same cycle.
- Run latency is 4·S cycles from start to done. Each vector is held for exactly S cycles.
- fail_mask and first_fail update live during the run; pass updates only at FINISH.
- Results hold until the next accepted start.

## Test plan
- S=4, truth=4'b0110, gate model = XOR: busy for 16 cycles, done at cycle 16, pass=1, fail_mask=0000, first_fail=0. Gate inputs sequence 00,01,10,11 with 4 cycles each.
- S=4, truth=4'b0110, gate model = AND: fail_mask=4'b1110, first_fail=1, pass=0, done at cycle 16.
- S=4, truth=4'b0110, gate_out stuck at 1: fail_mask=4'b1001, first_fail=0, pass=0.
- S=4, extra start pulses at cycles 3 and 9, plus truth changed to 4'b1111 at cycle 5, with an XOR gate: exactly one done at cycle 16, pass=1.
- S=4, reset_n driven low at cycle 7 for 2 cycles: all outputs 0 immediately and no done. A subsequent start gives a full 16-cycle run with pass=1.
- S=1, XOR gate, start held high continuously: done pulses every 5 cycles (4 RUN + 1 FINISH), pass=1 each run, and gate inputs return to 00 in each FINISH cycle.
